inst_fetch: RTL

//   Instruction-fetch initiator for the instruction ROM: owns the PC, drives the ROM

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch.sv | 84 ++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the fetch stage.
package inst_fetch_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam logic [ADDR_WIDTH-1:0] MEM_OFFSET = 32'h0000_1000;
  localparam logic [DATA_WIDTH-1:0] INST_NOP   = 32'h0000_0013;
  localparam int unsigned FETCH_DEPTH = 2;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous queue for fetched {pc,inst} pairs; flush beats push and pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  localparam logic [1:0] FULL = DEPTH[1:0];

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != FULL) || do_pop);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: cleared by reset so the queue reads empty immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; an entry is only ever read after it was written, since count gates the head.
    mem_q <= mem_d;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM each cycle, queues fetched
// words and presents them to decode; execute can redirect and flush the queue.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = MEM_OFFSET,
  parameter int unsigned           FIFO_DEPTH = FETCH_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  rom_ce_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_inst_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  id_ready_i,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_inst_o,
  output logic                  misalign_o
);

  localparam logic [1:0] FULL = FIFO_DEPTH[1:0];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  started_q, started_d;
  logic                  misalign_q, misalign_d;
  logic [1:0]            count;
  fetch_entry_t          head;
  fetch_entry_t          push_entry;
  logic                  pop;
  logic                  fetch;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fetch),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .count_o     (count),
    .head_o      (head)
  );

  // Fetch/redirect control and next PC; a redirect suppresses this cycle's fetch.
  always_comb begin
    pop        = if_valid_o && id_ready_i;
    fetch      = started_q && !redirect_i && ((count < FULL) || ((count == FULL) && pop));
    push_entry = '{pc: pc_q, inst: rom_inst_i};
    started_d  = 1'b1;
    misalign_d = redirect_i && (|redirect_pc_i[1:0]);
    pc_d       = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end

  // PC, start flag and misalign pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= started_d;
      misalign_q <= misalign_d;
    end
  end

  // Head presentation: empty queue reads as pc 0 / NOP.
  always_comb begin
    if_valid_o = (count != 2'd0);
    if_pc_o    = if_valid_o ? head.pc   : '0;
    if_inst_o  = if_valid_o ? head.inst : INST_NOP;
  end

  assign rom_ce_o   = fetch;
  assign rom_addr_o = pc_q;
  assign misalign_o = misalign_q;

endmodule
